// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants, flag indices and sequencer states for the FP divider
package fpu_pkg;

  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam logic [31:0] POS_INF   = 32'h7F800000;
  localparam logic [31:0] SIGN_MASK = 32'h80000000;
  localparam int          EXP_BIAS  = 127;
  localparam int          MANT_BITS = 23;

  // flags = {invalid, div_zero, overflow, underflow}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIVIDE,
    NORM,
    PACK,
    DONE
  } fpu_div_state_t;

endpackage

// File: rtl/fpu_div_seq_if.sv
// rtl/fpu_div_seq_if.sv - request/result handshake bundle of the FP divider
interface fpu_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/fpu_lzc24.sv
// rtl/fpu_lzc24.sv - combinational 24-bit leading-zero counter (24 for an all-zero input)
module fpu_lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // highest set bit wins because the scan runs upward
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fpu_div_seq.sv
// rtl/fpu_div_seq.sv - sequential IEEE-754 single divider; FPU_DIV_RNE_EN selects round-to-nearest-even
module fpu_div_seq
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  fpu_div_seq_if.slave bus
);

  localparam int DIV_CYCLES = (26 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;

  fpu_div_state_t     state, state_next;
  logic [31:0]        a_r, b_r, result_r;
  logic [3:0]         flags_r;
  logic [24:0]        rem, rem_step;
  logic [23:0]        mb;
  logic [25:0]        quo, quo_step;
  logic signed [9:0]  exp_r;
  logic               sign_r, special_r, pack_last;
  logic [4:0]         cnt;

  // operand classification and mantissa preparation
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [4:0]  lz_a, lz_b;
  logic [23:0] ma, mbc;
  logic signed [9:0] ea, eb, exp_calc;

  assign a_exp  = a_r[30:23];
  assign b_exp  = b_r[30:23];
  assign a_frac = a_r[22:0];
  assign b_frac = b_r[22:0];
  assign a_nan  = (&a_exp) & (|a_frac);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign a_inf  = (&a_exp) & ~(|a_frac);
  assign b_inf  = (&b_exp) & ~(|b_frac);
  assign a_zero = ~(|a_exp) & ~(|a_frac);
  assign b_zero = ~(|b_exp) & ~(|b_frac);

  fpu_lzc24 u_lzc_a (.value({1'b0, a_frac}), .count(lz_a));
  fpu_lzc24 u_lzc_b (.value({1'b0, b_frac}), .count(lz_b));

  // subnormals are pre-normalised so the divider always sees a leading one
  assign ma  = (a_exp == 8'd0) ? ({1'b0, a_frac} << lz_a) : {1'b1, a_frac};
  assign mbc = (b_exp == 8'd0) ? ({1'b0, b_frac} << lz_b) : {1'b1, b_frac};
  assign ea  = (a_exp == 8'd0) ? 10'sd1 - $signed({5'd0, lz_a}) : $signed({2'b00, a_exp});
  assign eb  = (b_exp == 8'd0) ? 10'sd1 - $signed({5'd0, lz_b}) : $signed({2'b00, b_exp});
  assign exp_calc = ea - eb + $signed(10'(EXP_BIAS));

  // special-case resolution in priority order
  logic        spec_hit;
  logic [31:0] spec_res, sign_word;
  logic [3:0]  spec_flags;
  assign sign_word = (a_r[31] ^ b_r[31]) ? SIGN_MASK : 32'd0;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = QNAN;
    spec_flags = 4'd0;
    if (a_nan | b_nan) begin
      spec_res = QNAN;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (b_zero) begin
      spec_res = sign_word | POS_INF;
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (a_inf) begin
      spec_res = sign_word | POS_INF;
    end else if (b_inf | a_zero) begin
      spec_res = sign_word;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // BITS_PER_CYCLE restoring shift/subtract steps per DIVIDE cycle
  always_comb begin
    rem_step = rem;
    quo_step = quo;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_step >= {1'b0, mb}) begin
        rem_step = rem_step - {1'b0, mb};
        quo_step = {quo_step[24:0], 1'b1};
      end else begin
        quo_step = {quo_step[24:0], 1'b0};
      end
      rem_step = rem_step << 1;
    end
  end

  // range handling and packing; quo[24:2] is the fraction, quo[1] the guard
  logic [31:0] pk_val;
  logic [3:0]  pk_flags;
  logic [4:0]  sh;
`ifdef FPU_DIV_RNE_EN
  logic        pk_g, pk_st;
  logic [25:0] lost_mask;
`endif

  always_comb begin
    pk_val   = {sign_r, 31'd0};
    pk_flags = 4'd0;
    sh       = 5'd1 - exp_r[4:0];
`ifdef FPU_DIV_RNE_EN
    pk_g      = 1'b0;
    pk_st     = 1'b0;
    lost_mask = (26'd1 << (sh + 5'd1)) - 26'd1;
`endif
    if (exp_r >= 10'sd255) begin
      pk_val = {sign_r, 8'hFF, 23'd0};
      pk_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      pk_flags[FLAG_UNDERFLOW] = 1'b1;
      if (exp_r > -10'sd24) begin
        pk_val = {sign_r, 8'd0, 23'(quo[25:2] >> sh)};
`ifdef FPU_DIV_RNE_EN
        pk_g  = quo[sh + 5'd1];
        pk_st = (|(quo & lost_mask)) | (|rem);
`endif
      end
    end else begin
      pk_val = {sign_r, exp_r[7:0], quo[24:2]};
`ifdef FPU_DIV_RNE_EN
      pk_g  = quo[1];
      pk_st = quo[0] | (|rem);
`endif
    end
  end

`ifdef FPU_DIV_RNE_EN
  logic        pack_phase, pend_g, pend_st, round_inc;
  logic [31:0] pend_val, rounded;
  logic [3:0]  pend_flags;
  assign round_inc = pend_g & (pend_st | pend_val[0]);
  assign rounded   = {pend_val[31], pend_val[30:0] + 31'(round_inc)};
  assign pack_last = special_r | pack_phase;
`else
  assign pack_last = 1'b1;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = CHECK;
      CHECK:   state_next = spec_hit ? PACK : DIVIDE;  // specials reuse the PACK slot
      DIVIDE:  if (cnt == 5'd0) state_next = NORM;
      NORM:    state_next = PACK;
      PACK:    if (pack_last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = result_r;
    bus.flags     = flags_r;
  end

  // datapath registers stepped by the sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; result_r <= '0; flags_r <= '0;
      rem <= '0; mb <= '0; quo <= '0; exp_r <= '0; cnt <= '0;
      sign_r <= 1'b0; special_r <= 1'b0;
`ifdef FPU_DIV_RNE_EN
      pack_phase <= 1'b0; pend_val <= '0; pend_g <= 1'b0; pend_st <= 1'b0; pend_flags <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r     <= bus.a;
          b_r     <= bus.b;
          flags_r <= 4'd0;
        end
        CHECK: begin
          sign_r    <= a_r[31] ^ b_r[31];
          special_r <= spec_hit;
          rem       <= {1'b0, ma};
          mb        <= mbc;
          quo       <= '0;
          exp_r     <= exp_calc;
          cnt       <= 5'(DIV_CYCLES - 1);
          if (spec_hit) begin
            result_r <= spec_res;
            flags_r  <= spec_flags;
          end
        end
        DIVIDE: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - 5'd1;
        end
        NORM: if (!quo[25]) begin
          quo   <= quo << 1;
          exp_r <= exp_r - 10'sd1;
        end
        PACK: if (!special_r) begin
`ifdef FPU_DIV_RNE_EN
          if (!pack_phase) begin
            pack_phase <= 1'b1;
            pend_val   <= pk_val;
            pend_g     <= pk_g;
            pend_st    <= pk_st;
            pend_flags <= pk_flags;
          end else begin
            pack_phase <= 1'b0;
            result_r   <= rounded;
            flags_r    <= pend_flags | ((rounded[30:23] == 8'hFF) ? 4'b0010 : 4'b0000);
          end
`else
          result_r <= pk_val;
          flags_r  <= pk_flags;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_seq.sv
// tb/tb_fpu_div_seq.sv - directed self-checking bench for fpu_div_seq (BITS_PER_CYCLE 1 and 2)
module tb_fpu_div_seq;
  import fpu_pkg::*;

`ifdef FPU_DIV_RNE_EN
  localparam int          RND_EXTRA = 1;
  localparam logic [31:0] THIRD     = 32'h3EAAAAAB;
`else
  localparam int          RND_EXTRA = 0;
  localparam logic [31:0] THIRD     = 32'h3EAAAAAA;
`endif
  localparam int LAT1 = 29 + RND_EXTRA;
  localparam int LAT2 = 16 + RND_EXTRA;
  localparam int LATS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_div_seq_if bus1();
  fpu_div_seq_if bus2();

  fpu_div_seq #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  fpu_div_seq #(.BITS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;
  int lat;

  logic        s_in_ready, s_out_valid, s_busy;
  logic [31:0] s_result;
  logic [3:0]  s_flags;

  always_comb begin
    s_in_ready  = (sel == 0) ? bus1.in_ready  : bus2.in_ready;
    s_out_valid = (sel == 0) ? bus1.out_valid : bus2.out_valid;
    s_busy      = (sel == 0) ? bus1.busy      : bus2.busy;
    s_result    = (sel == 0) ? bus1.result    : bus2.result;
    s_flags     = (sel == 0) ? bus1.flags     : bus2.flags;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv);
    if (sel == 0) begin bus1.in_valid = v; bus1.a = av; bus1.b = bv; end
    else          begin bus2.in_valid = v; bus2.a = av; bus2.b = bv; end
  endtask

  task automatic set_ready(input logic v);
    if (sel == 0) bus1.out_ready = v;
    else          bus2.out_ready = v;
  endtask

  // present one request; returns right after its acceptance edge E0
  task automatic start_op(input string tag, input logic [31:0] av, input logic [31:0] bv);
    int guard = 0;
    while (!s_in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    check($sformatf("%s in_ready", tag), 32'(s_in_ready), 32'd1);
    drive(1'b1, av, bv);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 32'd0);
  endtask

  // edges after E0 until out_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (!s_out_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic accept();
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags, input int exp_lat);
    int n;
    start_op(tag, av, bv);
    wait_valid(n);
    check($sformatf("%s latency", tag), 32'(n), 32'(exp_lat));
    check($sformatf("%s result", tag), s_result, exp_res);
    check($sformatf("%s flags", tag), {28'd0, s_flags}, {28'd0, exp_flags});
    accept();
    check($sformatf("%s idle after accept", tag), 32'(s_in_ready), 32'd1);
  endtask

  initial begin
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  32'(bus1.in_ready),  32'd1);
    check("reset out_valid", 32'(bus1.out_valid), 32'd0);
    check("reset busy",      32'(bus1.busy),      32'd0);
    check("reset result",    bus1.result,         32'd0);
    check("reset flags",     {28'd0, bus1.flags}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    sel = 0;
    run_op("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT1);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, THIRD,        4'b0000, LAT1);
    run_op("one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, LATS);
    run_op("neg_by_zero",  32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, LATS);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, LATS);
    run_op("nan_operand",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, LATS);
    run_op("inf_by_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, LATS);
    run_op("inf_by_two",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, LATS);
    run_op("two_by_inf",   32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, LATS);
    run_op("overflow",     32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, LAT1);
    run_op("underflow",    32'h00800000, 32'h40000000, 32'h00400000, 4'b0001, LAT1);
    run_op("min_sub",      32'h00000001, 32'h00000001, 32'h3F800000, 4'b0000, LAT1);
    run_op("neg_quot",     32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, LAT1);

    // result held while the consumer stalls; in_valid pulses must be ignored
    start_op("stall", 32'h40C00000, 32'h40000000);
    wait_valid(lat);
    check("stall latency", 32'(lat), 32'(LAT1));
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 32'h3F800000, 32'h40400000);
      @(posedge clk); #1;
      check($sformatf("stall result %0d", i), s_result, 32'h40400000);
      check($sformatf("stall in_ready %0d", i), 32'(s_in_ready), 32'd0);
      check($sformatf("stall out_valid %0d", i), 32'(s_out_valid), 32'd1);
    end
    drive(1'b0, 32'd0, 32'd0);
    accept();
    @(posedge clk); #1;
    check("stall no phantom op", 32'(s_busy), 32'd0);

    // reset while dividing aborts without output
    start_op("abort", 32'h40C00000, 32'h40000000);
    repeat (5) @(posedge clk);
    #1;
    check("abort busy before", 32'(s_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort in_ready",  32'(s_in_ready),  32'd1);
    check("abort out_valid", 32'(s_out_valid), 32'd0);
    check("abort busy",      32'(s_busy),      32'd0);
    check("abort result",    s_result,         32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort stays quiet", 32'(s_out_valid), 32'd0);
    run_op("after_abort", 32'h3F800000, 32'h40400000, THIRD, 4'b0000, LAT1);

    // two quotient bits per cycle, then back-to-back traffic
    sel = 1;
    run_op("bpc2_six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT2);
    run_op("bpc2_b2b_0", 32'h3F800000, 32'h40400000, THIRD,        4'b0000, LAT2);
    run_op("bpc2_b2b_1", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, LATS);
    run_op("bpc2_b2b_2", 32'h00800000, 32'h40000000, 32'h00400000, 4'b0001, LAT2);
    run_op("bpc2_b2b_3", 32'h00000001, 32'h00000001, 32'h3F800000, 4'b0000, LAT2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
